// File: rtl/voice_frame_sched_pkg.sv
// Shared definitions for the voice frame scheduler.
// Holds the sequencing FSM state encoding, the Q3.7 pitch-ratio
// fraction width, the default frame/FIFO/timeout sizes, and the
// saturation value for the pitch ratio.
package voice_frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FILL,
    CAPTURE,
    LINEAR,
    FILTER,
    DRAIN
  } state_t;

  // Pitch ratio p is Q3.7: 7 fraction bits, so 1.0 == 128.
  localparam int FRAC_W = 7;

  localparam int FRAME_LEN_DEF = 600;
  localparam int OUT_DEPTH_DEF = 2048;
  localparam int TIMEOUT_DEF   = 4095;

  localparam logic [9:0] P_MAX = 10'd1023;

endpackage

// File: rtl/ratio_div.sv
// Sequential restoring divider for the pitch ratio.
// Divides a 17-bit numerator by a 10-bit denominator, one quotient bit
// per cycle, and saturates the result to P_MAX on divide-by-zero or when
// the quotient does not fit in 10 bits.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (aborts a division)
//   start       - 1-cycle pulse, samples num/den and performs the first step
//   num [16:0]  - dividend
//   den [9:0]   - divisor
//   done        - 1-cycle pulse when q is valid (17 cycles after start)
//   q [9:0]     - saturated quotient, held until the next completion
module ratio_div
  import voice_frame_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] num,
  input  logic [9:0]  den,
  output logic        done,
  output logic [9:0]  q
);

  logic [9:0]  den_r;
  logic [9:0]  rem;
  logic [16:0] num_sh;
  logic [15:0] quo;
  logic [4:0]  cnt;
  logic        running;

  logic [9:0]  step_rem_in;
  logic        step_msb;
  logic [9:0]  step_den;
  logic [10:0] trial;
  logic        step_bit;
  logic [9:0]  step_rem;
  logic [16:0] quo_next;

  // One restoring step. On start the step works directly on the new
  // operands so the full 17 bits finish within 17 cycles of start.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    step_rem_in = start ? 10'd0 : rem;
    step_msb    = start ? num[16] : num_sh[16];
    step_den    = start ? den : den_r;
    trial       = {step_rem_in, step_msb};
    step_bit    = (trial >= {1'b0, step_den});
    // When the trial is below the divisor it is at most 1022, so it fits 10 bits.
    step_rem    = step_bit ? 10'(trial - {1'b0, step_den}) : trial[9:0];
    quo_next    = {quo, step_bit};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      den_r   <= '0;
      rem     <= '0;
      num_sh  <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        den_r   <= den;
        rem     <= step_rem;
        num_sh  <= {num[15:0], 1'b0};
        quo     <= {15'd0, step_bit};
        cnt     <= 5'd1;
        running <= 1'b1;
      end else if (running) begin
        rem    <= step_rem;
        num_sh <= {num_sh[15:0], 1'b0};
        quo    <= quo_next[15:0];
        cnt    <= cnt + 5'd1;
        if (cnt == 5'd16) begin
          running <= 1'b0;
          done    <= 1'b1;
          q       <= ((den_r == 10'd0) || (quo_next > {7'd0, P_MAX})) ? P_MAX : quo_next[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/voice_frame_sched.sv
// Voice frame scheduler: gates frames on FIFO water levels, fills a
// ping-pong frame RAM, sequences the capture/linear/filter stages with a
// per-stage timeout, drains the filtered frame into the output FIFO and
// publishes the Q3.7 pitch ratio p = f_set / f_original for each frame.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   enable                    - run frames (a started frame always completes)
//   f_set, f_original         - target / source pitch
//   in_level, out_level       - input FIFO read level, output FIFO write level
//   in_rd_en                  - input FIFO pop
//   wr_en, wr_bank, wr_addr   - frame RAM write port
//   new_bank                  - bank holding the newest complete frame
//   p                         - pitch ratio, Q3.7, saturated at 1023
//   *_start / *_done          - stage handshake pulses
//   drain_addr, out_wr_en     - filter RAM read address, output FIFO push
//   busy, err, frame_cnt      - status: not idle, stage timeout, frames done
module voice_frame_sched
  import voice_frame_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [9:0]  f_set,
  input  logic [9:0]  f_original,
  input  logic [11:0] in_level,
  input  logic [11:0] out_level,
  output logic        in_rd_en,
  output logic        wr_en,
  output logic        wr_bank,
  output logic [9:0]  wr_addr,
  output logic        new_bank,
  output logic [9:0]  p,
  output logic        cap_start,
  output logic        lin_start,
  output logic        flt_start,
  input  logic        cap_done,
  input  logic        lin_done,
  input  logic        flt_done,
  output logic [9:0]  drain_addr,
  output logic        out_wr_en,
  output logic        busy,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam int              TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [9:0]      FL_LAST     = 10'(FRAME_LEN - 1);
  localparam logic [11:0]     FL_LVL      = 12'(FRAME_LEN);
  // OUT_DEPTH - out_level >= FRAME_LEN, rearranged to avoid an underflowing subtract.
  localparam logic [11:0]     OUT_LVL_MAX = 12'(OUT_DEPTH - FRAME_LEN);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [9:0]      P_ONE       = 10'(1 << FRAC_W);

  state_t          state;
  logic [9:0]      rd_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            drain_act;
  logic            div_ready;
  logic            div_done;
  logic [9:0]      div_q;
  logic            fill_go;

  assign fill_go = (state == WAIT) && enable &&
                   (in_level >= FL_LVL) && (out_level <= OUT_LVL_MAX);
  assign busy    = (state != IDLE);

  ratio_div u_div (
    .clk   (clk),
    .rst   (rst),
    .start (fill_go),
    .num   ({f_set, {FRAC_W{1'b0}}}),
    .den   (f_original),
    .done  (div_done),
    .q     (div_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_rd_en   <= 1'b0;
      wr_en      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      new_bank   <= 1'b1;
      p          <= P_ONE;
      cap_start  <= 1'b0;
      lin_start  <= 1'b0;
      flt_start  <= 1'b0;
      drain_addr <= '0;
      drain_act  <= 1'b0;
      out_wr_en  <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
      rd_cnt     <= '0;
      to_cnt     <= '0;
      div_ready  <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the cycle they apply.
      cap_start <= 1'b0;
      lin_start <= 1'b0;
      flt_start <= 1'b0;
      err       <= 1'b0;

      // RAM write trails the FIFO pop by its one-cycle read latency; same
      // for the output push trailing the filter RAM read.
      wr_en     <= in_rd_en;
      out_wr_en <= drain_act;
      if (in_rd_en) wr_addr <= rd_cnt;
      if (div_done) div_ready <= 1'b1;

      unique case (state)
        IDLE: if (enable) state <= WAIT;

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (fill_go) begin
            state     <= FILL;
            in_rd_en  <= 1'b1;
            rd_cnt    <= '0;
            div_ready <= 1'b0;
          end
        end

        FILL: begin
          if (in_rd_en) begin
            if (rd_cnt == FL_LAST) in_rd_en <= 1'b0;
            else                   rd_cnt   <= rd_cnt + 10'd1;
          end else if (wr_en) begin
            // Last RAM write is in flight: publish the bank and ratio.
            new_bank  <= wr_bank;
            wr_bank   <= ~wr_bank;
            cap_start <= 1'b1;
            to_cnt    <= '0;
            state     <= CAPTURE;
            if (div_ready) p <= div_q;
          end
        end

        CAPTURE: begin
          if (cap_done) begin
            state     <= LINEAR;
            lin_start <= 1'b1;
            to_cnt    <= '0;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= WAIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        LINEAR: begin
          if (lin_done) begin
            state     <= FILTER;
            flt_start <= 1'b1;
            to_cnt    <= '0;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= WAIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        FILTER: begin
          if (flt_done) begin
            state      <= DRAIN;
            drain_addr <= '0;
            drain_act  <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= WAIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        DRAIN: begin
          if (drain_act) begin
            if (drain_addr == FL_LAST) drain_act  <= 1'b0;
            else                       drain_addr <= drain_addr + 10'd1;
          end else if (out_wr_en) begin
            // Final push is this cycle; the frame is complete.
            frame_cnt <= frame_cnt + 16'd1;
            state     <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_frame_sched.sv
module tb_voice_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  f_set, f_original;
  logic [11:0] in_level, out_level;
  logic        in_rd_en, wr_en, wr_bank, new_bank;
  logic [9:0]  wr_addr, p, drain_addr;
  logic        cap_start, lin_start, flt_start;
  logic        cap_done, lin_done, flt_done;
  logic        out_wr_en, busy, err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  voice_frame_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .f_set      (f_set),
    .f_original (f_original),
    .in_level   (in_level),
    .out_level  (out_level),
    .in_rd_en   (in_rd_en),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .new_bank   (new_bank),
    .p          (p),
    .cap_start  (cap_start),
    .lin_start  (lin_start),
    .flt_start  (flt_start),
    .cap_done   (cap_done),
    .lin_done   (lin_done),
    .flt_done   (flt_done),
    .drain_addr (drain_addr),
    .out_wr_en  (out_wr_en),
    .busy       (busy),
    .err        (err),
    .frame_cnt  (frame_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int rd; int wr; int last_addr; int p; int wr_bank; int new_bank;
  } cap_rec_t;
  typedef struct {
    int cnt; int pushes; int p;
  } done_rec_t;

  cap_rec_t  cap_q[$];
  done_rec_t done_q[$];
  cap_rec_t  cr;
  done_rec_t dr;

  // Monitor state
  int          cyc = 0;
  int          rd_run = 0, wr_run = 0, last_addr = -1, overlap = 0;
  int          push_frame = 0, push_total = 0;
  int          cap_cnt = 0, lin_cnt = 0, err_cnt = 0;
  int          lin_cyc = 0, err_cyc = 0;
  logic [15:0] prev_cnt = 16'd0;

  // Stage responder controls (written only by the stimulus process)
  int auto_lin  = 1;
  int stray_req = 0;
  int stray_ack = 0;
  int cap_dly = 0, lin_dly = 0, flt_dly = 0;

  // Stage responder: each done pulse follows its start by 10 cycles.
  always @(negedge clk) begin
    cap_done = 1'b0;
    lin_done = 1'b0;
    flt_done = 1'b0;
    if (cap_dly > 0) begin cap_dly--; if (cap_dly == 0) cap_done = 1'b1; end
    if (lin_dly > 0) begin lin_dly--; if (lin_dly == 0) lin_done = 1'b1; end
    if (flt_dly > 0) begin flt_dly--; if (flt_dly == 0) flt_done = 1'b1; end
    if (cap_start) cap_dly = 10;
    if (lin_start && auto_lin != 0) lin_dly = 10;
    if (flt_start) flt_dly = 10;
    if (stray_req != stray_ack) begin
      flt_done  = 1'b1;
      stray_ack = stray_req;
    end
  end

  // Scoreboard monitor: pops an expected record whenever a frame is
  // published (cap_start) or completed (frame_cnt changes).
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_run     = 0;
      wr_run     = 0;
      overlap    = 0;
      push_frame = 0;
      prev_cnt   = 16'd0;
    end else begin
      if (in_rd_en) rd_run++;
      if (wr_en) begin wr_run++; last_addr = int'(wr_addr); end
      if (in_rd_en && out_wr_en) overlap++;
      if (out_wr_en) begin push_frame++; push_total++; end
      if (lin_start) begin lin_cnt++; lin_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (cap_start) begin
        cap_cnt++;
        if (cap_q.size() == 0) begin
          check("unexpected_cap_start", cap_cnt, 0);
        end else begin
          cr = cap_q.pop_front();
          check("fill_rd_cycles", rd_run, cr.rd);
          check("fill_wr_cycles", wr_run, cr.wr);
          check("fill_last_wr_addr", last_addr, cr.last_addr);
          check("fill_push_overlap", overlap, 0);
          check("cap_p", int'(p), cr.p);
          check("cap_wr_bank", int'(wr_bank), cr.wr_bank);
          check("cap_new_bank", int'(new_bank), cr.new_bank);
        end
        rd_run  = 0;
        wr_run  = 0;
        overlap = 0;
      end
      if (frame_cnt != prev_cnt) begin
        if (done_q.size() == 0) begin
          check("unexpected_frame_done", int'(frame_cnt), int'(prev_cnt));
        end else begin
          dr = done_q.pop_front();
          check("done_frame_cnt", int'(frame_cnt), dr.cnt);
          check("done_pushes", push_frame, dr.pushes);
          check("done_p", int'(p), dr.p);
        end
        push_frame = 0;
        prev_cnt   = frame_cnt;
      end
    end
  end

  task automatic push_cap(input int pv, input int wb, input int nb);
    cap_rec_t r;
    r.rd = 600; r.wr = 600; r.last_addr = 599;
    r.p = pv; r.wr_bank = wb; r.new_bank = nb;
    cap_q.push_back(r);
  endtask

  task automatic push_done(input int cnt, input int pv);
    done_rec_t r;
    r.cnt = cnt; r.pushes = 600; r.p = pv;
    done_q.push_back(r);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  int snap;

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    f_set      = 10'd200;
    f_original = 10'd100;
    in_level   = 12'd0;
    out_level  = 12'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_wr_bank", int'(wr_bank), 0);
    check("rst_new_bank", int'(new_bank), 1);
    check("rst_p", int'(p), 128);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_drain_addr", int'(drain_addr), 0);
    check("rst_in_rd_en", int'(in_rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_out_wr_en", int'(out_wr_en), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;

    // Input level one short of a frame: no pop.
    enable    = 1'b1;
    in_level  = 12'd599;
    out_level = 12'd1448;
    repeat (20) @(negedge clk);
    check("wait_busy", int'(busy), 1);
    check("no_rd_in_level_599", rd_run, 0);

    // Enough input but only 548 free output slots: still waiting.
    in_level  = 12'd600;
    out_level = 12'd1500;
    repeat (20) @(negedge clk);
    check("no_rd_out_space_548", rd_run, 0);

    // Frames 1 and 2 run back to back with p = 200*128/100 = 256.
    push_cap(256, 1, 0);
    push_done(1, 256);
    push_cap(256, 0, 1);
    push_done(2, 256);
    out_level = 12'd1448;
    for (int i = 0; i < 50 && !in_rd_en; i++) @(negedge clk);
    check("fill_started", int'(in_rd_en), 1);
    stray_req++;

    // During frame 2 LINEAR, change f_set; frame 2 keeps p=256, frame 3 gets 384.
    for (int i = 0; i < 4000 && lin_cnt < 2; i++) @(negedge clk);
    check("reach_frame2_linear", lin_cnt, 2);
    f_set = 10'd300;
    check("p_hold_in_linear", int'(p), 256);
    push_cap(384, 1, 0);
    push_done(3, 384);

    for (int i = 0; i < 3000 && frame_cnt != 16'd2; i++) @(negedge clk);
    check("two_frames_done", int'(frame_cnt), 2);
    check("two_frames_pushes", push_total, 1200);

    // Drop enable mid frame 3: it must finish, then go idle.
    for (int i = 0; i < 2000 && cap_cnt < 3; i++) @(negedge clk);
    check("reach_frame3_capture", cap_cnt, 3);
    enable     = 1'b0;
    f_original = 10'd0;
    for (int i = 0; i < 2000 && frame_cnt != 16'd3; i++) @(negedge clk);
    check("frame3_done", int'(frame_cnt), 3);
    repeat (3) @(negedge clk);
    check("idle_after_frame3", int'(busy), 0);
    check("three_frames_pushes", push_total, 1800);

    // Frame 4: f_original=0 saturates p; lin_done withheld -> timeout.
    push_cap(1023, 0, 1);
    auto_lin = 0;
    enable   = 1'b1;
    for (int i = 0; i < 2000 && lin_cnt < 4; i++) @(negedge clk);
    check("reach_frame4_linear", lin_cnt, 4);
    enable = 1'b0;
    for (int i = 0; i < 5000 && err_cnt < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("err_pulse_count", err_cnt, 1);
    check("err_delay", err_cyc - lin_cyc, 4095);
    check("timeout_frame_cnt", int'(frame_cnt), 3);
    check("timeout_wr_bank", int'(wr_bank), 0);
    check("timeout_idle", int'(busy), 0);
    check("timeout_p", int'(p), 1023);

    // Frame 5: reset in the middle of the drain.
    auto_lin   = 1;
    f_set      = 10'd200;
    f_original = 10'd100;
    push_cap(256, 1, 0);
    enable = 1'b1;
    for (int i = 0; i < 3000 && !(out_wr_en && drain_addr == 10'd300); i++) @(negedge clk);
    check("reach_drain_300", int'(drain_addr), 300);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_out_wr_en", int'(out_wr_en), 0);
    check("abort_drain_addr", int'(drain_addr), 0);
    check("abort_p", int'(p), 128);
    check("abort_frame_cnt", int'(frame_cnt), 0);
    check("abort_wr_bank", int'(wr_bank), 0);
    check("abort_new_bank", int'(new_bank), 1);
    @(negedge clk);
    rst  = 1'b0;
    snap = push_total;
    repeat (20) @(negedge clk);
    check("no_push_after_abort", push_total, snap);
    check("no_pop_after_abort", rd_run, 0);
    check("cap_queue_drained", cap_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
